// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter: sticky pending bitmap per source, one-hot registered
// grant with valid/ready handshake, plus a saturating duplicate-request counter.

module rr_req_arbiter_lane (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    input  logic mask,
    input  logic offered,
    output logic pend,
    output logic elig,
    output logic hit
);
    // Set wins over clear so a re-request during accept keeps the source pending.
    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= (pend & ~clr) | set;
    end

    assign elig = pend & ~mask & ~offered;
    assign hit  = set & pend;
endmodule

module rr_req_arbiter #(
    parameter int NUMW = 4,
    parameter int BITW = 2**NUMW,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITW-1:0] req_set,
    input  logic [BITW-1:0] req_mask,
    input  logic            gnt_rdy,
    output logic            gnt_vld,
    output logic [BITW-1:0] gnt_map,
    output logic [BITW-1:0] pend,
    output logic [CNTW-1:0] dup_cnt
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;
    localparam int SUMW = CNTW + NUMW + 1;
    localparam logic [SUMW-1:0] DUP_MAX = SUMW'((1 << CNTW) - 1);

    logic [0:0]      state;
    logic [NUMW-1:0] ptr, gnt_idx;
    logic            acc;
    logic [BITW-1:0] clr_map, offered, elig, hit;

    assign gnt_vld = (state == OFFER);
    assign acc     = gnt_vld & gnt_rdy;
    assign clr_map = acc ? gnt_map : '0;
    assign offered = gnt_vld ? gnt_map : '0;

    for (genvar i = 0; i < BITW; i++) begin : g_lane
        rr_req_arbiter_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .set    (req_set[i]),
            .clr    (clr_map[i]),
            .mask   (req_mask[i]),
            .offered(offered[i]),
            .pend   (pend[i]),
            .elig   (elig[i]),
            .hit    (hit[i])
        );
    end

    logic [NUMW:0]   hit_cnt;
    logic [SUMW-1:0] dup_sum;
    logic [CNTW-1:0] dup_nxt;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < BITW; i++) hit_cnt = hit_cnt + (NUMW+1)'(hit[i]);
        dup_sum = SUMW'(dup_cnt) + SUMW'(hit_cnt);
        dup_nxt = (dup_sum > DUP_MAX) ? DUP_MAX[CNTW-1:0] : dup_sum[CNTW-1:0];
    end

    // On accept the scan already starts past the granted index, enabling back-to-back grants.
    logic [NUMW-1:0]   base, off, sel_idx;
    logic [2*BITW-1:0] dbl;
    logic [BITW-1:0]   rot, sel_map;
    logic              found, any_elig;

    assign base     = acc ? gnt_idx + NUMW'(1) : ptr;
    assign dbl      = {elig, elig} >> base;
    assign rot      = dbl[BITW-1:0];
    assign any_elig = |elig;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < BITW; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = NUMW'(i);
            end
        end
        sel_idx = base + off;
        sel_map = BITW'(1) << sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_map <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            dup_cnt <= '0;
        end else begin
            dup_cnt <= dup_nxt;
            if (state == IDLE) begin
                if (any_elig) begin
                    state   <= OFFER;
                    gnt_map <= sel_map;
                    gnt_idx <= sel_idx;
                end
            end else if (gnt_rdy) begin
                ptr <= gnt_idx + NUMW'(1);
                if (any_elig) begin
                    gnt_map <= sel_map;
                    gnt_idx <= sel_idx;
                end else begin
                    state   <= IDLE;
                    gnt_map <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: latency, round-robin wrap, backpressure,
// masking, set/clear collision, duplicate saturation and reset during offer.

module tb_rr_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_set, req_mask;
    logic        gnt_rdy;
    logic        gnt_vld;
    logic [15:0] gnt_map, pend;
    logic [7:0]  dup_cnt;

    int total = 0;
    int fails = 0;

    rr_req_arbiter #(.NUMW(4), .BITW(16), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_set (req_set),
        .req_mask(req_mask),
        .gnt_rdy (gnt_rdy),
        .gnt_vld (gnt_vld),
        .gnt_map (gnt_map),
        .pend    (pend),
        .dup_cnt (dup_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_set = '0; req_mask = '0; gnt_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_vld", gnt_vld, 0);
        chk("rst_map", gnt_map, 0);
        chk("rst_pend", pend, 0);
        chk("rst_dup", dup_cnt, 0);

        // 1. latency
        req_set = 16'h0001; gnt_rdy = 1'b1;
        tick(); req_set = '0;
        chk("lat_pend_c2", pend, 16'h0001);
        chk("lat_vld_c2", gnt_vld, 0);
        tick();
        chk("lat_vld_c3", gnt_vld, 1);
        chk("lat_map_c3", gnt_map, 16'h0001);
        tick();
        chk("lat_vld_c4", gnt_vld, 0);
        chk("lat_pend_c4", pend, 0);

        // 2. round robin and wrap
        do_reset();
        req_set = 16'h8011; gnt_rdy = 1'b1;
        tick(); req_set = '0;
        chk("rr_pend", pend, 16'h8011);
        tick(); chk("rr_g0", gnt_map, 16'h0001);
        tick(); chk("rr_g1", gnt_map, 16'h0010);
        tick(); chk("rr_g2", gnt_map, 16'h8000);
        chk("rr_g2_vld", gnt_vld, 1);
        tick(); chk("rr_idle", gnt_vld, 0);
        chk("rr_idle_map", gnt_map, 0);
        req_set = 16'h0003;
        tick(); req_set = '0;
        tick(); chk("wrap_g0", gnt_map, 16'h0001);
        tick(); chk("wrap_g1", gnt_map, 16'h0002);
        tick(); chk("wrap_idle", gnt_vld, 0);

        // 3. backpressure (ptr = 2)
        gnt_rdy = 1'b0; req_set = 16'h0004;
        tick(); req_set = '0;
        tick(); chk("bp_offer", gnt_map, 16'h0004);
        req_set = 16'h0002; req_mask = 16'h0004;
        for (int c = 0; c < 5; c++) begin
            tick(); req_set = '0;
            chk("bp_hold_map", gnt_map, 16'h0004);
            chk("bp_hold_vld", gnt_vld, 1);
        end
        gnt_rdy = 1'b1; req_mask = '0;
        tick(); chk("bp_next", gnt_map, 16'h0002);
        tick(); chk("bp_idle", gnt_vld, 0);

        // 4. mask (ptr = 2)
        gnt_rdy = 1'b0; req_set = 16'h0003; req_mask = 16'h0001;
        tick(); req_set = '0;
        tick(); chk("mask_g", gnt_map, 16'h0002);
        tick(); chk("mask_hold", gnt_map, 16'h0002);
        req_mask = '0; gnt_rdy = 1'b1;
        tick(); chk("mask_clr_g", gnt_map, 16'h0001);
        tick(); chk("mask_idle", gnt_vld, 0);

        // 5. set and clear on the same bit
        do_reset();
        req_set = 16'h0021;
        tick(); req_set = '0;
        tick(); chk("sc_offer", gnt_map, 16'h0001);
        req_set = 16'h0001; gnt_rdy = 1'b1;
        tick(); req_set = '0;
        chk("sc_g1", gnt_map, 16'h0020);
        chk("sc_pend1", pend, 16'h0021);
        chk("sc_dup", dup_cnt, 1);
        tick(); chk("sc_g2", gnt_map, 16'h0001);
        chk("sc_pend2", pend, 16'h0001);
        tick(); chk("sc_idle", gnt_vld, 0);
        chk("sc_pend3", pend, 0);

        // 6. duplicates, saturation, reset during offer
        do_reset();
        req_set = 16'h0004;
        tick(); tick(); tick();
        chk("dup_3req", dup_cnt, 2);
        for (int c = 0; c < 250; c++) tick();
        chk("dup_252", dup_cnt, 252);
        for (int c = 0; c < 50; c++) tick();
        chk("dup_sat", dup_cnt, 255);
        req_set = 16'h000C;
        tick();
        chk("dup_sat_multi", dup_cnt, 255);
        chk("pre_rst_vld", gnt_vld, 1);
        chk("pre_rst_map", gnt_map, 16'h0004);
        rst = 1'b1; gnt_rdy = 1'b1;
        tick(); rst = 1'b0; req_set = '0;
        chk("rst_offer_vld", gnt_vld, 0);
        chk("rst_offer_map", gnt_map, 0);
        chk("rst_offer_pend", pend, 0);
        chk("rst_offer_dup", dup_cnt, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
